// File: rtl/vector_reflect_pipe_if.sv
// Handshake/data bundle between the intersection stage, vector_reflect_pipe and the secondary-ray generator.
// The producer/consumer side uses the master modport; the reflector uses the slave modport.
interface vector_reflect_pipe_if #(
    parameter int W  = 32,
    parameter int TW = 8
);
    logic           in_valid;
    logic           in_ready;
    logic           in_mode;
    logic [3*W-1:0] in_v;
    logic [3*W-1:0] in_n;
    logic [TW-1:0]  in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [3*W-1:0] out_r;
    logic [TW-1:0]  out_tag;
    logic           out_sat;

    modport master (
        output in_valid, in_mode, in_v, in_n, in_tag, out_ready,
        input  in_ready, out_valid, out_r, out_tag, out_sat
    );

    modport slave (
        input  in_valid, in_mode, in_v, in_n, in_tag, out_ready,
        output in_ready, out_valid, out_r, out_tag, out_sat
    );
endinterface

// File: rtl/vector_reflect_pipe.sv
// Fixed-point 3-vector reflect (v - 2(v.n)n) / project (v - (v.n)n) pipeline feeding a credit-guarded FWFT FIFO.
// Optional feature macro: VREFL_SATURATE_EN (clip results to W bits and raise out_sat); default build wraps.
module vector_reflect_pipe #(
    parameter int W     = 32,
    parameter int FRAC  = 16,
    parameter int TW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    vector_reflect_pipe_if.slave bus
);
    localparam int PW  = 2 * W;
    localparam int SW  = 2 * W + 2;
    localparam int KW  = 2 * W + 3;
    localparam int KNW = 3 * W + 3;
    localparam int RW  = 3 * W + 4;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int LW  = CW + 3;
    localparam int EW  = 3 * W + TW + 1;

`ifdef VREFL_SATURATE_EN
    localparam logic signed [RW-1:0] R_MAX = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [RW-1:0] R_MIN = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic clip_flag(input logic signed [RW-1:0] x);
        return (x > R_MAX) || (x < R_MIN);
    endfunction

    function automatic logic signed [W-1:0] reduce_w(input logic signed [RW-1:0] x);
        if (x > R_MAX) return {1'b0, {(W-1){1'b1}}};
        if (x < R_MIN) return {1'b1, {(W-1){1'b0}}};
        return W'(x);
    endfunction
`else
    function automatic logic signed [W-1:0] reduce_w(input logic signed [RW-1:0] x);
        return W'(x);
    endfunction
`endif

    logic                   vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q, vld_p5_q;
    logic                   mode_p0_q, mode_p1_q;
    logic [TW-1:0]          tag_p0_q, tag_p1_q, tag_p2_q, tag_p3_q, tag_p4_q, tag_p5_q;
    logic signed [W-1:0]    v_p0_q [3];
    logic signed [W-1:0]    v_p1_q [3];
    logic signed [W-1:0]    v_p2_q [3];
    logic signed [W-1:0]    v_p3_q [3];
    logic signed [W-1:0]    n_p0_q [3];
    logic signed [W-1:0]    n_p1_q [3];
    logic signed [W-1:0]    n_p2_q [3];
    logic signed [PW-1:0]   prod_p1_q [3];
    logic signed [SW-1:0]   dot_p2_d;
    logic signed [SW-1:0]   d_p2_d;
    logic signed [KW-1:0]   k_p2_d, k_p2_q;
    logic signed [KNW-1:0]  kn_p3_q [3];
    logic signed [KNW-1:0]  p_p4_d [3];
    logic signed [RW-1:0]   rf_p4_d [3];
    logic signed [RW-1:0]   rf_p4_q [3];
    logic signed [W-1:0]    r_p5_d [3];
    logic signed [W-1:0]    r_p5_q [3];
    logic                   sat_p5_d, sat_p5_q;

    logic [CW-1:0]          cnt_d, cnt_q;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [2:0]             inflight;
    logic [LW-1:0]          used;
    logic                   acc, pop;
    logic [EW-1:0]          mem [DEPTH];
    logic [EW-1:0]          head;

    // Credit: every in-flight stage already owns a FIFO slot, so the FIFO can never overflow.
    assign inflight = 3'(vld_p0_q) + 3'(vld_p1_q) + 3'(vld_p2_q)
                    + 3'(vld_p3_q) + 3'(vld_p4_q) + 3'(vld_p5_q);
    assign used          = LW'(cnt_q) + LW'(inflight);
    assign bus.in_ready  = !rst && (used < LW'(DEPTH));
    assign acc           = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (cnt_q != '0);
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            vld_p4_q <= 1'b0;
            vld_p5_q <= 1'b0;
        end else begin
            vld_p0_q <= acc;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            vld_p4_q <= vld_p3_q;
            vld_p5_q <= vld_p4_q;
        end
    end

    // p0: input capture, only on an accepting edge
    always_ff @(posedge clk) begin
        if (acc) begin
            mode_p0_q <= bus.in_mode;
            tag_p0_q  <= bus.in_tag;
            for (int i = 0; i < 3; i++) begin
                v_p0_q[i] <= bus.in_v[i*W +: W];
                n_p0_q[i] <= bus.in_n[i*W +: W];
            end
        end
    end

    // p1: full-precision component products
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            prod_p1_q[i] <= PW'(v_p0_q[i]) * PW'(n_p0_q[i]);
            v_p1_q[i]    <= v_p0_q[i];
            n_p1_q[i]    <= n_p0_q[i];
        end
        mode_p1_q <= mode_p0_q;
        tag_p1_q  <= tag_p0_q;
    end

    // p2: dot sum, floor shift, mode scale (reflect doubles d)
    always_comb begin
        dot_p2_d = SW'(prod_p1_q[0]) + SW'(prod_p1_q[1]) + SW'(prod_p1_q[2]);
        d_p2_d   = dot_p2_d >>> FRAC;
        k_p2_d   = mode_p1_q ? KW'(d_p2_d) : (KW'(d_p2_d) <<< 1);
    end

    always_ff @(posedge clk) begin
        k_p2_q <= k_p2_d;
        for (int i = 0; i < 3; i++) begin
            v_p2_q[i] <= v_p1_q[i];
            n_p2_q[i] <= n_p1_q[i];
        end
        tag_p2_q <= tag_p1_q;
    end

    // p3: k * n_i products
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            kn_p3_q[i] <= KNW'(k_p2_q) * KNW'(n_p2_q[i]);
            v_p3_q[i]  <= v_p2_q[i];
        end
        tag_p3_q <= tag_p2_q;
    end

    // p4: shift and subtract at full width
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            p_p4_d[i]  = kn_p3_q[i] >>> FRAC;
            rf_p4_d[i] = RW'(v_p3_q[i]) - RW'(p_p4_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            rf_p4_q[i] <= rf_p4_d[i];
        end
        tag_p4_q <= tag_p3_q;
    end

    // p5: reduce to W bits
    always_comb begin
        sat_p5_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r_p5_d[i] = reduce_w(rf_p4_q[i]);
`ifdef VREFL_SATURATE_EN
            sat_p5_d = sat_p5_d | clip_flag(rf_p4_q[i]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            r_p5_q[i] <= r_p5_d[i];
        end
        sat_p5_q <= sat_p5_d;
        tag_p5_q <= tag_p4_q;
    end

    // Output FIFO, first-word-fall-through
    always_comb begin
        cnt_d = cnt_q;
        if (vld_p5_q && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!vld_p5_q && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (vld_p5_q) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p5_q) begin
            mem[wr_ptr_q] <= {r_p5_q[2], r_p5_q[1], r_p5_q[0], tag_p5_q, sat_p5_q};
        end
    end

    // Outputs read as zero whenever the FIFO is empty, including straight after reset.
    assign head        = mem[rd_ptr_q];
    assign bus.out_r   = bus.out_valid ? head[EW-1 -: 3*W] : '0;
    assign bus.out_tag = bus.out_valid ? head[TW:1] : '0;
    assign bus.out_sat = bus.out_valid & head[0];
endmodule

// File: tb/tb_vector_reflect_pipe.sv
// Self-checking bench for vector_reflect_pipe: directed reflect/project/overflow cases, backpressure,
// random streaming against an arithmetic reference model, and mid-stream reset.
module tb_vector_reflect_pipe;
    localparam int W     = 32;
    localparam int FRAC  = 16;
    localparam int TW    = 8;
    localparam int DEPTH = 8;
    localparam int EW    = 3 * W + TW + 1;

    localparam logic [3*W-1:0] V_A    = {32'h0, 32'hFFFF0000, 32'h00010000};
    localparam logic [3*W-1:0] N_A    = {32'h0, 32'h00010000, 32'h00000000};
    localparam logic [3*W-1:0] R_REFL = {32'h0, 32'h00010000, 32'h00010000};
    localparam logic [3*W-1:0] R_PROJ = {32'h0, 32'h00000000, 32'h00010000};
    localparam logic [3*W-1:0] V_O    = {32'h0, 32'h0, 32'h7FFF0000};
    localparam logic [3*W-1:0] N_O    = {32'h0, 32'h0, 32'h00020000};
`ifdef VREFL_SATURATE_EN
    localparam logic [3*W-1:0] R_O    = {32'h0, 32'h0, 32'h80000000};
    localparam logic           SAT_O  = 1'b1;
`else
    localparam logic [3*W-1:0] R_O    = {32'h0, 32'h0, 32'h80070000};
    localparam logic           SAT_O  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vector_reflect_pipe_if #(.W(W), .TW(TW)) bus ();

    vector_reflect_pipe #(.W(W), .FRAC(FRAC), .TW(TW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference: r_i = v_i - ((k * n_i) >> FRAC), k = (v.n >> FRAC) scaled by 2 for reflect.
    function automatic void ref_model(input logic mode, input logic [3*W-1:0] v, input logic [3*W-1:0] n,
                                      output logic [3*W-1:0] r, output logic sat);
        logic signed [127:0] dot, k, p, rr, vi, ni, maxv, minv;
        maxv = (128'sd1 <<< (W - 1)) - 128'sd1;
        minv = -(128'sd1 <<< (W - 1));
        dot = 0;
        for (int i = 0; i < 3; i++) begin
            vi = $signed(v[i*W +: W]);
            ni = $signed(n[i*W +: W]);
            dot = dot + vi * ni;
        end
        k = dot >>> FRAC;
        if (!mode) k = k * 2;
        sat = 1'b0;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            vi = $signed(v[i*W +: W]);
            ni = $signed(n[i*W +: W]);
            p  = (k * ni) >>> FRAC;
            rr = vi - p;
`ifdef VREFL_SATURATE_EN
            if (rr > maxv) begin
                r[i*W +: W] = 32'h7FFFFFFF;
                sat = 1'b1;
            end else if (rr < minv) begin
                r[i*W +: W] = 32'h80000000;
                sat = 1'b1;
            end else begin
                r[i*W +: W] = rr[W-1:0];
            end
`else
            r[i*W +: W] = rr[W-1:0];
            if (rr > maxv || rr < minv) sat = 1'b0;
`endif
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_mode  = 1'b0;
        bus.in_v     = '0;
        bus.in_n     = '0;
        bus.in_tag   = '0;
    endtask

    task automatic rand_fields(output logic mode, output logic [3*W-1:0] v, output logic [3*W-1:0] n);
        mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3; i++) begin
            v[i*W +: W] = $urandom();
            n[i*W +: W] = $urandom();
        end
    endtask

    // Sends one transaction (out_ready assumed high) and reports edges from accept to out_valid.
    task automatic run_one(input logic mode, input logic [3*W-1:0] v, input logic [3*W-1:0] n,
                           input logic [TW-1:0] tag, output logic [3*W-1:0] r, output logic [TW-1:0] otag,
                           output logic osat, output int lat);
        int w;
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_v     = v;
        bus.in_n     = n;
        bus.in_tag   = tag;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            tick();
            w++;
        end
        tick();
        drive_idle();
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            tick();
            lat++;
        end
        r    = bus.out_r;
        otag = bus.out_tag;
        osat = bus.out_sat;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus.out_ready = 1'b0;
        repeat (3) tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_r !== '0) begin bad++; $display("FAIL reset_out_r got=%h want=0", bus.out_r); end
        total++; if (bus.out_tag !== '0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", bus.out_tag); end
        total++; if (bus.out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b want=0", bus.out_sat); end
        rst = 1'b0;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_out_valid got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_reflect();
        logic [3*W-1:0] r; logic [TW-1:0] t; logic s; int lat;
        bus.out_ready = 1'b1;
        run_one(1'b0, V_A, N_A, 8'h5A, r, t, s, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL reflect_latency got=%0d want=6", lat); end
        total++; if (r !== R_REFL) begin bad++; $display("FAIL reflect_r got=%h want=%h", r, R_REFL); end
        total++; if (t !== 8'h5A) begin bad++; $display("FAIL reflect_tag got=%h want=5a", t); end
        total++; if (s !== 1'b0) begin bad++; $display("FAIL reflect_sat got=%b want=0", s); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reflect_pop_empty got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_project();
        logic [3*W-1:0] r; logic [TW-1:0] t; logic s; int lat;
        run_one(1'b1, V_A, N_A, 8'hC3, r, t, s, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL project_latency got=%0d want=6", lat); end
        total++; if (r !== R_PROJ) begin bad++; $display("FAIL project_r got=%h want=%h", r, R_PROJ); end
        total++; if (t !== 8'hC3) begin bad++; $display("FAIL project_tag got=%h want=c3", t); end
        tick();
    endtask

    task automatic test_overflow();
        logic [3*W-1:0] r; logic [TW-1:0] t; logic s; int lat;
        run_one(1'b0, V_O, N_O, 8'h11, r, t, s, lat);
        total++; if (r !== R_O) begin bad++; $display("FAIL overflow_r got=%h want=%h", r, R_O); end
        total++; if (s !== SAT_O) begin bad++; $display("FAIL overflow_sat got=%b want=%b", s, SAT_O); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] exp_q[$];
        logic [EW-1:0] e;
        logic [TW-1:0] acc_tags[$];
        logic [3*W-1:0] v, n, r;
        logic m, s;
        int w;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_fields(m, v, n);
            bus.in_valid = 1'b1;
            bus.in_mode  = m;
            bus.in_v     = v;
            bus.in_n     = n;
            bus.in_tag   = TW'(i);
            if (bus.in_ready) begin
                ref_model(m, v, n, r, s);
                exp_q.push_back({r, TW'(i), s});
                acc_tags.push_back(TW'(i));
            end
            tick();
        end
        drive_idle();
        total++; if (acc_tags.size() !== DEPTH) begin bad++; $display("FAIL bp_accept_count got=%0d want=%0d", acc_tags.size(), DEPTH); end
        for (int j = 0; j < acc_tags.size(); j++) begin
            total++; if (acc_tags[j] !== TW'(j)) begin bad++; $display("FAIL bp_accept_tag got=%h want=%h", acc_tags[j], TW'(j)); end
        end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full got=%b want=0", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            total++;
            if (bus.out_valid !== 1'b1 || {bus.out_r, bus.out_tag, bus.out_sat} !== e) begin
                bad++;
                $display("FAIL bp_drain valid=%b got=%h want=%h", bus.out_valid, {bus.out_r, bus.out_tag, bus.out_sat}, e);
            end
            tick();
        end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained_valid got=%b want=0", bus.out_valid); end
        w = 0;
        while (!bus.in_ready && w < 20) begin tick(); w++; end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_back got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_streaming();
        logic [EW-1:0] exp_q[$];
        logic [EW-1:0] e;
        logic [3*W-1:0] v, n, r;
        logic [TW-1:0] t;
        logic m, s;
        int sent, rcv, cyc, drops, first, last;
        sent = 0; rcv = 0; cyc = 0; drops = 0; first = -1; last = -1;
        bus.out_ready = 1'b1;
        while ((sent < 100 || rcv < 100) && cyc < 400) begin
            if (bus.out_valid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                total++;
                if ({bus.out_r, bus.out_tag, bus.out_sat} !== e) begin
                    bad++;
                    $display("FAIL stream_out n=%0d got=%h want=%h", rcv, {bus.out_r, bus.out_tag, bus.out_sat}, e);
                end
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            if (sent < 100) begin
                rand_fields(m, v, n);
                t = TW'($urandom());
                bus.in_valid = 1'b1;
                bus.in_mode  = m;
                bus.in_v     = v;
                bus.in_n     = n;
                bus.in_tag   = t;
                if (!bus.in_ready) begin
                    drops++;
                end else begin
                    ref_model(m, v, n, r, s);
                    exp_q.push_back({r, t, s});
                    sent++;
                end
            end else begin
                drive_idle();
            end
            tick();
            cyc++;
        end
        drive_idle();
        total++; if (drops !== 0) begin bad++; $display("FAIL stream_in_ready_drops got=%0d want=0", drops); end
        total++; if (rcv !== 100) begin bad++; $display("FAIL stream_count got=%0d want=100", rcv); end
        total++; if (last - first !== 99) begin bad++; $display("FAIL stream_rate span got=%0d want=99", last - first); end
    endtask

    task automatic test_reset_mid();
        logic [3*W-1:0] v, n, r;
        logic [TW-1:0] t;
        logic m, s;
        int lat, seen;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_fields(m, v, n);
            bus.in_valid = 1'b1;
            bus.in_mode  = m;
            bus.in_v     = v;
            bus.in_n     = n;
            bus.in_tag   = TW'(8'hA0 + i);
            tick();
        end
        drive_idle();
        tick();
        rst = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_in_ready_high got=%b want=0", bus.in_ready); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready_after got=%b want=1", bus.in_ready); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_ghost_outputs got=%0d want=0", seen); end
        run_one(1'b0, V_A, N_A, 8'h77, r, t, s, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL rstmid_latency got=%0d want=6", lat); end
        total++; if (r !== R_REFL || t !== 8'h77) begin bad++; $display("FAIL rstmid_result got=%h/%h want=%h/77", r, t, R_REFL); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reflect();
        test_project();
        test_overflow();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
